mem_port_arbiter: RTL

- Shares one 4B memory port between two requesters: port 0 is instruction fetch, port 1 is data access.
- Arbitrates requests round-robin and tags each request with its source in the opaque field.
- Routes each response back to its source by tag.
- Tracks outstanding requests per port, so a dual-port processor core can run on a single-ported memory.

---
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter onto one shared memory port, with opaque
// tagging of requests and tag-based routing of responses back to their source.
module mem_port_arbiter #(
  parameter int unsigned p_max_outstanding = 2
) (
  input  logic        clk,
  input  logic        reset,

  input  logic [76:0] req0_msg,
  input  logic        req0_val,
  output logic        req0_rdy,
  input  logic [76:0] req1_msg,
  input  logic        req1_val,
  output logic        req1_rdy,

  output logic [46:0] resp0_msg,
  output logic        resp0_val,
  input  logic        resp0_rdy,
  output logic [46:0] resp1_msg,
  output logic        resp1_val,
  input  logic        resp1_rdy,

  output logic [76:0] memreq_msg,
  output logic        memreq_val,
  input  logic        memreq_rdy,
  input  logic [46:0] memresp_msg,
  input  logic        memresp_val,
  output logic        memresp_rdy,

  output logic        err
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] MAX_OUT = CNT_W'(p_max_outstanding);

  localparam logic [0:0] PRIO_P0 = 1'b0;

  logic             r_prio;
  logic             w_prio_nxt;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;
  logic [CNT_W-1:0] w_cnt0_nxt;
  logic [CNT_W-1:0] w_cnt1_nxt;
  logic             r_err;
  logic             w_err_nxt;

  logic        w_elig0;
  logic        w_elig1;
  logic        w_any;
  logic        w_gnt;
  logic        w_fire;
  logic [76:0] w_sel;
  logic        w_dst;
  logic        w_inc0;
  logic        w_inc1;
  logic        w_dec0;
  logic        w_dec1;
  logic        w_under0;
  logic        w_under1;

  // Request side: eligibility, grant and tagging (all outputs forced idle in reset)
  assign w_elig0 = reset & req0_val & (r_cnt0 < MAX_OUT);
  assign w_elig1 = reset & req1_val & (r_cnt1 < MAX_OUT);
  assign w_any   = w_elig0 | w_elig1;
  assign w_gnt   = (w_elig0 & w_elig1) ? r_prio : w_elig1;
  assign w_fire  = w_any & memreq_rdy;

  assign memreq_val = w_any;
  assign req0_rdy   = w_any & ~w_gnt & memreq_rdy;
  assign req1_rdy   = w_any &  w_gnt & memreq_rdy;

  assign w_sel      = w_gnt ? req1_msg : req0_msg;
  assign memreq_msg = {w_sel[76:74], w_sel[72:66], w_gnt, w_sel[65:0]};

  // Response side: source port is carried in opaque bit 0
  assign w_dst       = memresp_msg[36];
  assign resp0_val   = reset & memresp_val & ~w_dst;
  assign resp1_val   = reset & memresp_val &  w_dst;
  assign memresp_rdy = reset & (w_dst ? resp1_rdy : resp0_rdy);
  assign resp0_msg   = {memresp_msg[46:44], 1'b0, memresp_msg[43:37], memresp_msg[35:0]};
  assign resp1_msg   = resp0_msg;

  assign w_inc0   = w_fire & ~w_gnt;
  assign w_inc1   = w_fire &  w_gnt;
  assign w_dec0   = resp0_val & resp0_rdy;
  assign w_dec1   = resp1_val & resp1_rdy;
  assign w_under0 = w_dec0 & (r_cnt0 == '0);
  assign w_under1 = w_dec1 & (r_cnt1 == '0);

  assign err = r_err;

  // Saturating-at-zero in-flight counter step
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                input logic inc, input logic dec);
    cnt_next = c;
    if (inc && !dec)
      cnt_next = c + CNT_W'(1);
    else if (dec && !inc && (c != '0))
      cnt_next = c - CNT_W'(1);
  endfunction

  always_comb begin
    w_prio_nxt = r_prio;
    w_cnt0_nxt = r_cnt0;
    w_cnt1_nxt = r_cnt1;
    w_err_nxt  = r_err;
    if (w_fire)
      w_prio_nxt = ~w_gnt;
    w_cnt0_nxt = cnt_next(r_cnt0, w_inc0, w_dec0);
    w_cnt1_nxt = cnt_next(r_cnt1, w_inc1, w_dec1);
    if (w_under0 || w_under1)
      w_err_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prio <= PRIO_P0;
      r_cnt0 <= '0;
      r_cnt1 <= '0;
      r_err  <= 1'b0;
    end else begin
      r_prio <= w_prio_nxt;
      r_cnt0 <= w_cnt0_nxt;
      r_cnt1 <= w_cnt1_nxt;
      r_err  <= w_err_nxt;
    end
  end

endmodule
